// File: rtl/jt51_pkg.sv
// Shared constants for the YM2151-compatible CPU/timer shell: register map,
// control/status bit positions and the offset-binary DAC helper.
package jt51_pkg;

    localparam logic [7:0] ADDR_CLKA_HI = 8'h10;
    localparam logic [7:0] ADDR_CLKA_LO = 8'h11;
    localparam logic [7:0] ADDR_CLKB    = 8'h12;
    localparam logic [7:0] ADDR_CTRL    = 8'h14;
    localparam logic [7:0] ADDR_CT      = 8'h1B;

    localparam int CTRL_LOAD_A  = 0;
    localparam int CTRL_LOAD_B  = 1;
    localparam int CTRL_IRQEN_A = 2;
    localparam int CTRL_IRQEN_B = 3;
    localparam int CTRL_RST_A   = 4;
    localparam int CTRL_RST_B   = 5;

    localparam int CT1_BIT = 6;
    localparam int CT2_BIT = 7;

    localparam int ST_FLAG_A = 0;
    localparam int ST_FLAG_B = 1;
    localparam int ST_BUSY   = 7;

    function automatic logic [15:0] to_dac(input logic [15:0] x);
        return {~x[15], x[14:0]};
    endfunction

endpackage

// File: rtl/jt51_top_timer.sv
// Up-counting YM2151 timer: reloads on LOAD rising edge and on overflow,
// raises a sticky flag on overflow when enabled; the flag reset strobe wins.
module jt51_top_timer #(
    parameter int W = 10
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         tick_i,
    input  logic         load_i,
    input  logic         irqen_i,
    input  logic         flag_rst_i,
    input  logic [W-1:0] start_i,
    output logic         flag_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         load_prev_q;
    logic         flag_q, flag_d;
    logic         ovf;

    always_comb begin
        cnt_d  = cnt_q;
        ovf    = 1'b0;
        flag_d = flag_q;
        if (load_i && !load_prev_q) begin
            cnt_d = start_i;
        end else if (load_i && tick_i) begin
            if (&cnt_q) begin
                cnt_d = start_i;
                ovf   = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        if (flag_rst_i) begin
            flag_d = 1'b0;
        end else if (ovf && irqen_i) begin
            flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q       <= '0;
            load_prev_q <= 1'b0;
            flag_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            load_prev_q <= load_i;
            flag_q      <= flag_d;
        end
    end

    assign flag_o = flag_q;

endmodule

// File: rtl/jt51_top.sv
// YM2151-compatible host interface shell: write port, status, timers A/B with
// IRQ, CT1/CT2, sample strobe and (idle) audio output formatting.
module jt51_top
    import jt51_pkg::*;
#(
    parameter int BUSY_TICKS = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cen,
    input  logic               cen_p1,
    input  logic               cs_n,
    input  logic               wr_n,
    input  logic               a0,
    input  logic [7:0]         din,
    output logic [7:0]         dout,
    output logic               ct1,
    output logic               ct2,
    output logic               irq_n,
    output logic               sample,
    output logic signed [15:0] left,
    output logic signed [15:0] right,
    output logic signed [15:0] xleft,
    output logic signed [15:0] xright,
    output logic [15:0]        dacleft,
    output logic [15:0]        dacright
);

    localparam logic [7:0] BUSY_LAST = 8'(BUSY_TICKS - 1);

    logic        wr_prev_q;
    logic [7:0]  addr_q, addr_d;
    logic [9:0]  clka_q, clka_d;
    logic [7:0]  clkb_q, clkb_d;
    logic        load_a_q, load_a_d, load_b_q, load_b_d;
    logic        irqen_a_q, irqen_a_d, irqen_b_q, irqen_b_d;
    logic        ct1_q, ct1_d, ct2_q, ct2_d;
    logic        busy_q, busy_d;
    logic [7:0]  busy_cnt_q, busy_cnt_d;
    logic [4:0]  pre_a_q, pre_a_d;
    logic [3:0]  pre_b_q, pre_b_d;
    logic        irq_n_q, irq_n_d;
    logic [15:0] left_q, left_d, right_q, right_d;

    logic wr_act, wr_stb, addr_wr, data_wr, ctrl_wr;
    logic phi1, tick_a, tick_b;
    logic flag_a, flag_b, flag_rst_a, flag_rst_b;

    // cen_p1 only counts when it lands on a cen pulse.
    assign phi1    = cen & cen_p1;
    assign tick_a  = phi1 && (pre_a_q == 5'd31);
    assign tick_b  = tick_a && (pre_b_q == 4'd15);

    assign wr_act  = ~cs_n & ~wr_n;
    assign wr_stb  = wr_act & ~wr_prev_q;
    assign addr_wr = wr_stb & ~a0;
    assign data_wr = wr_stb & a0;
    assign ctrl_wr = data_wr && (addr_q == ADDR_CTRL);

    assign flag_rst_a = ctrl_wr && din[CTRL_RST_A];
    assign flag_rst_b = ctrl_wr && din[CTRL_RST_B];

    // CSM (control bit 7) has no effect in this shell, so it is not kept.
    always_comb begin
        addr_d    = addr_q;
        clka_d    = clka_q;
        clkb_d    = clkb_q;
        load_a_d  = load_a_q;
        load_b_d  = load_b_q;
        irqen_a_d = irqen_a_q;
        irqen_b_d = irqen_b_q;
        ct1_d     = ct1_q;
        ct2_d     = ct2_q;
        if (addr_wr) addr_d = din;
        if (data_wr) begin
            case (addr_q)
                ADDR_CLKA_HI: clka_d[9:2] = din;
                ADDR_CLKA_LO: clka_d[1:0] = din[1:0];
                ADDR_CLKB:    clkb_d      = din;
                ADDR_CTRL: begin
                    load_a_d  = din[CTRL_LOAD_A];
                    load_b_d  = din[CTRL_LOAD_B];
                    irqen_a_d = din[CTRL_IRQEN_A];
                    irqen_b_d = din[CTRL_IRQEN_B];
                end
                ADDR_CT: begin
                    ct1_d = din[CT1_BIT];
                    ct2_d = din[CT2_BIT];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy_d     = busy_q;
        busy_cnt_d = busy_cnt_q;
        if (data_wr) begin
            busy_d     = 1'b1;
            busy_cnt_d = '0;
        end else if (busy_q && phi1) begin
            busy_cnt_d = busy_cnt_q + 1'b1;
            if (busy_cnt_q == BUSY_LAST) busy_d = 1'b0;
        end
        pre_a_d = phi1   ? pre_a_q + 1'b1 : pre_a_q;
        pre_b_d = tick_a ? pre_b_q + 1'b1 : pre_b_q;
        irq_n_d = ~(flag_a | flag_b);
        left_d  = tick_a ? (xleft  & 16'hFFE0) : left_q;
        right_d = tick_a ? (xright & 16'hFFE0) : right_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_prev_q  <= 1'b0;
            addr_q     <= '0;
            clka_q     <= '0;
            clkb_q     <= '0;
            load_a_q   <= 1'b0;
            load_b_q   <= 1'b0;
            irqen_a_q  <= 1'b0;
            irqen_b_q  <= 1'b0;
            ct1_q      <= 1'b0;
            ct2_q      <= 1'b0;
            busy_q     <= 1'b0;
            busy_cnt_q <= '0;
            pre_a_q    <= '0;
            pre_b_q    <= '0;
            irq_n_q    <= 1'b1;
            left_q     <= '0;
            right_q    <= '0;
        end else begin
            wr_prev_q  <= wr_act;
            addr_q     <= addr_d;
            clka_q     <= clka_d;
            clkb_q     <= clkb_d;
            load_a_q   <= load_a_d;
            load_b_q   <= load_b_d;
            irqen_a_q  <= irqen_a_d;
            irqen_b_q  <= irqen_b_d;
            ct1_q      <= ct1_d;
            ct2_q      <= ct2_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
            pre_a_q    <= pre_a_d;
            pre_b_q    <= pre_b_d;
            irq_n_q    <= irq_n_d;
            left_q     <= left_d;
            right_q    <= right_d;
        end
    end

    jt51_top_timer #(.W(10)) u_timer_a (
        .clk_i(clk), .rst_i(rst), .tick_i(tick_a), .load_i(load_a_q),
        .irqen_i(irqen_a_q), .flag_rst_i(flag_rst_a), .start_i(clka_q), .flag_o(flag_a)
    );

    jt51_top_timer #(.W(8)) u_timer_b (
        .clk_i(clk), .rst_i(rst), .tick_i(tick_b), .load_i(load_b_q),
        .irqen_i(irqen_b_q), .flag_rst_i(flag_rst_b), .start_i(clkb_q), .flag_o(flag_b)
    );

    always_comb begin
        dout            = '0;
        dout[ST_BUSY]   = busy_q;
        dout[ST_FLAG_B] = flag_b;
        dout[ST_FLAG_A] = flag_a;
    end

    // The operator pipeline lives elsewhere, so the full-resolution mix is silent.
    assign xleft    = '0;
    assign xright   = '0;
    assign left     = left_q;
    assign right    = right_q;
    assign dacleft  = to_dac(xleft);
    assign dacright = to_dac(xright);
    assign ct1      = ct1_q;
    assign ct2      = ct2_q;
    assign irq_n    = irq_n_q;
    assign sample   = tick_a;

endmodule

// File: tb/tb_jt51_top.sv
// Directed bench for jt51_top: reset values, sample period, timers A/B, IRQ
// enable, busy flag, CT outputs, held write strobe and mid-run reset.
module tb_jt51_top;

    logic clk = 1'b0, rst = 1'b1, cen = 1'b0, cen_p1 = 1'b0;
    logic cs_n = 1'b1, wr_n = 1'b1, a0 = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic ct1, ct2, irq_n, sample;
    logic signed [15:0] left, right, xleft, xright;
    logic [15:0] dacleft, dacright;

    int total = 0;
    int bad   = 0;
    int div   = 0;

    jt51_top #(.BUSY_TICKS(32)) dut (
        .clk(clk), .rst(rst), .cen(cen), .cen_p1(cen_p1), .cs_n(cs_n), .wr_n(wr_n),
        .a0(a0), .din(din), .dout(dout), .ct1(ct1), .ct2(ct2), .irq_n(irq_n),
        .sample(sample), .left(left), .right(right), .xleft(xleft), .xright(xright),
        .dacleft(dacleft), .dacright(dacright)
    );

    always #5 clk = ~clk;

    // cen every 4 clk, cen_p1 every 8 clk (on every other cen)
    always @(posedge clk) begin
        #1;
        div    = div + 1;
        cen    = (div % 4 == 0);
        cen_p1 = (div % 8 == 0);
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic a, input logic [7:0] d);
        @(negedge clk);
        cs_n = 1'b0; wr_n = 1'b0; a0 = a; din = d;
        @(negedge clk);
        cs_n = 1'b1; wr_n = 1'b1;
    endtask

    task automatic reg_write(input logic [7:0] addr, input logic [7:0] d);
        bus_write(1'b0, addr);
        bus_write(1'b1, d);
    endtask

    task automatic wait_sample(input int limit, output bit found);
        found = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (sample) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_cenp1(input int limit, output bit found);
        found = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk);
            if (cen_p1) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        wait_clks(3);
        total++; if (dout !== 8'h00) begin bad++; $display("FAIL reset_dout: got %h want 00", dout); end
        total++; if (irq_n !== 1'b1) begin bad++; $display("FAIL reset_irq_n: got %b want 1", irq_n); end
        total++; if ({ct2, ct1} !== 2'b00) begin bad++; $display("FAIL reset_ct: got %b want 00", {ct2, ct1}); end
        total++; if (sample !== 1'b0) begin bad++; $display("FAIL reset_sample: got %b want 0", sample); end
        total++; if (left !== 16'sh0 || right !== 16'sh0 || xleft !== 16'sh0 || xright !== 16'sh0) begin
            bad++; $display("FAIL reset_audio: got %h %h %h %h want 0", left, right, xleft, xright);
        end
        total++; if (dacleft !== 16'h8000 || dacright !== 16'h8000) begin
            bad++; $display("FAIL reset_dac: got %h %h want 8000", dacleft, dacright);
        end
        rst = 1'b0;
        wait_clks(2);
        total++; if (dout !== 8'h00 || irq_n !== 1'b1) begin
            bad++; $display("FAIL post_reset: got dout=%h irq_n=%b want 00/1", dout, irq_n);
        end
    endtask

    task automatic test_sample_period;
        bit found;
        int n;
        wait_sample(400, found);
        total++; if (!found) begin bad++; $display("FAIL sample_seen: got none want pulse"); end
        n = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            n++;
            if (sample) break;
        end
        total++; if (n != 256) begin bad++; $display("FAIL sample_period: got %0d clk want 256", n); end
        total++; if (left !== 16'sh0 || dacleft !== 16'h8000) begin
            bad++; $display("FAIL sample_audio: got %h %h want 0000 8000", left, dacleft);
        end
    endtask

    task automatic test_timer_a;
        bit found;
        wait_sample(400, found);
        reg_write(8'h10, 8'hFF);
        reg_write(8'h11, 8'h03);
        reg_write(8'h14, 8'h05);
        wait_sample(400, found);
        total++; if (!found) begin bad++; $display("FAIL ta_tick: got none want sample"); end
        total++; if (dout[1:0] !== 2'b00 || irq_n !== 1'b1) begin
            bad++; $display("FAIL ta_before: got flags=%b irq_n=%b want 00/1", dout[1:0], irq_n);
        end
        wait_clks(1);
        total++; if (dout[1:0] !== 2'b01) begin bad++; $display("FAIL ta_flag: got %b want 01", dout[1:0]); end
        wait_clks(1);
        total++; if (irq_n !== 1'b0) begin bad++; $display("FAIL ta_irq: got %b want 0", irq_n); end
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (dout[7] === 1'b0) begin found = 1'b1; break; end
        end
        total++; if (!found || dout !== 8'h01) begin
            bad++; $display("FAIL ta_dout: got %h want 01", dout);
        end
        reg_write(8'h14, 8'h15);
        total++; if (dout !== 8'h80) begin bad++; $display("FAIL ta_clear_dout: got %h want 80", dout); end
        wait_clks(1);
        total++; if (irq_n !== 1'b1) begin bad++; $display("FAIL ta_clear_irq: got %b want 1", irq_n); end
    endtask

    task automatic test_timer_b;
        bit found;
        int nsamp;
        reg_write(8'h14, 8'h30);
        reg_write(8'h12, 8'hFF);
        reg_write(8'h14, 8'h0A);
        found = 1'b0;
        nsamp = 0;
        for (int i = 0; i < 4700; i++) begin
            @(negedge clk);
            if (sample) nsamp++;
            if (dout[1] === 1'b1) begin found = 1'b1; break; end
        end
        total++; if (!found || nsamp < 1 || nsamp > 16) begin
            bad++; $display("FAIL tb_flag: got found=%b after %0d samples want 1..16", found, nsamp);
        end
        total++; if (dout[1:0] !== 2'b10) begin bad++; $display("FAIL tb_dout: got %b want 10", dout[1:0]); end
        wait_clks(1);
        total++; if (irq_n !== 1'b0) begin bad++; $display("FAIL tb_irq: got %b want 0", irq_n); end
    endtask

    task automatic test_irq_disabled;
        bit found;
        reg_write(8'h14, 8'h30);
        wait_clks(1);
        total++; if (dout[1:0] !== 2'b00 || irq_n !== 1'b1) begin
            bad++; $display("FAIL irqdis_clear: got flags=%b irq_n=%b want 00/1", dout[1:0], irq_n);
        end
        bus_write(1'b1, 8'h01);
        wait_sample(400, found);
        wait_sample(400, found);
        wait_clks(2);
        total++; if (dout[1:0] !== 2'b00 || irq_n !== 1'b1) begin
            bad++; $display("FAIL irqdis_run: got flags=%b irq_n=%b want 00/1", dout[1:0], irq_n);
        end
    endtask

    task automatic test_busy_ct;
        bit found;
        reg_write(8'h1B, 8'hC0);
        total++; if ({ct2, ct1} !== 2'b11) begin bad++; $display("FAIL ct_c0: got %b want 11", {ct2, ct1}); end
        total++; if (dout[7] !== 1'b1) begin bad++; $display("FAIL busy_set: got %b want 1", dout[7]); end
        for (int i = 0; i < 31; i++) wait_cenp1(20, found);
        @(negedge clk);
        total++; if (dout[7] !== 1'b1) begin bad++; $display("FAIL busy_31: got %b want 1", dout[7]); end
        wait_cenp1(20, found);
        @(negedge clk);
        total++; if (dout[7] !== 1'b0) begin bad++; $display("FAIL busy_32: got %b want 0", dout[7]); end
        bus_write(1'b1, 8'h40);
        total++; if ({ct2, ct1} !== 2'b01) begin bad++; $display("FAIL ct_40: got %b want 01", {ct2, ct1}); end
    endtask

    task automatic test_held_low;
        reg_write(8'h1B, 8'h00);
        @(negedge clk);
        cs_n = 1'b0; wr_n = 1'b0; a0 = 1'b0; din = 8'h1B;
        @(negedge clk);
        din = 8'h14;
        repeat (4) @(negedge clk);
        cs_n = 1'b1; wr_n = 1'b1;
        bus_write(1'b1, 8'hC0);
        total++; if ({ct2, ct1} !== 2'b11) begin bad++; $display("FAIL held_low: got ct=%b want 11", {ct2, ct1}); end
    endtask

    task automatic test_reset_mid;
        bit found;
        reg_write(8'h14, 8'h05);
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (dout[0] === 1'b1) begin found = 1'b1; break; end
        end
        wait_clks(1);
        total++; if (!found || irq_n !== 1'b0) begin
            bad++; $display("FAIL mid_setup: got flag=%b irq_n=%b want 1/0", found, irq_n);
        end
        rst = 1'b1;
        wait_clks(1);
        total++; if (dout !== 8'h00 || irq_n !== 1'b1) begin
            bad++; $display("FAIL mid_rst_status: got dout=%h irq_n=%b want 00/1", dout, irq_n);
        end
        total++; if ({ct2, ct1} !== 2'b00 || dacleft !== 16'h8000 || sample !== 1'b0) begin
            bad++; $display("FAIL mid_rst_out: got ct=%b dac=%h sample=%b want 00/8000/0", {ct2, ct1}, dacleft, sample);
        end
        rst = 1'b0;
        wait_sample(400, found);
        wait_sample(400, found);
        wait_clks(2);
        total++; if (dout !== 8'h00 || irq_n !== 1'b1) begin
            bad++; $display("FAIL mid_after: got dout=%h irq_n=%b want 00/1", dout, irq_n);
        end
    endtask

    initial begin
        test_reset;
        test_sample_period;
        test_timer_a;
        test_timer_b;
        test_irq_disabled;
        test_busy_ct;
        test_held_low;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
